// File: rtl/reg_rename_alloc.sv
// Rename/allocation stage: architectural-to-physical map table, circular free list
// and per-tag busy bits, with a one-cycle registered renamed-instruction output.
module reg_rename_alloc #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic          dec_uses_rs,
  input  logic          dec_uses_rt,
  input  logic          dec_uses_rw,
  input  logic [4:0]    dec_rs,
  input  logic [4:0]    dec_rt,
  input  logic [4:0]    dec_rw,
  output logic          ren_valid,
  output logic          ren_uses_rs,
  output logic          ren_uses_rt,
  output logic          ren_uses_rw,
  output logic [PW-1:0] ren_rs_phys,
  output logic [PW-1:0] ren_rt_phys,
  output logic [PW-1:0] ren_rw_phys,
  output logic [PW-1:0] ren_old_rw_phys,
  output logic          ren_rs_busy,
  output logic          ren_rt_busy,
  input  logic          wb_valid,
  input  logic [PW-1:0] wb_phys,
  input  logic          commit_valid,
  input  logic [PW-1:0] commit_free_phys,
  output logic [PW:0]   free_count,
  output logic          overflow_err
);

  localparam int          FREE_INIT = PHYS_REGS - ARCH_REGS;
  localparam logic [PW:0] FULL_CNT  = (PW+1)'(PHYS_REGS);
  localparam logic [PW:0] INIT_CNT  = (PW+1)'(FREE_INIT);

  logic [PW-1:0]        map       [ARCH_REGS];
  logic [PW-1:0]        free_list [PHYS_REGS];
  logic [PHYS_REGS-1:0] busy;
  logic [PW-1:0]        head, tail;

  logic          alloc, accept, pop, push, commit_req;
  logic [PW-1:0] rs_tag, rt_tag, new_tag, old_tag;
  logic          rs_busy, rt_busy;

  always_comb begin
    alloc      = dec_uses_rw && (dec_rw != '0);
    dec_ready  = !alloc || (free_count != '0);
    accept     = dec_valid && dec_ready;
    pop        = accept && alloc;
    commit_req = commit_valid && (commit_free_phys != '0);
    push       = commit_req && (free_count != FULL_CNT);
    rs_tag     = dec_uses_rs ? map[dec_rs] : '0;
    rt_tag     = dec_uses_rt ? map[dec_rt] : '0;
    // a write-back landing in the lookup cycle already counts as done
    rs_busy    = dec_uses_rs && busy[rs_tag] && !(wb_valid && (wb_phys == rs_tag));
    rt_busy    = dec_uses_rt && busy[rt_tag] && !(wb_valid && (wb_phys == rt_tag));
    new_tag    = free_list[head];
    old_tag    = map[dec_rw];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) map[i] <= PW'(i);
    end else if (pop) begin
      map[dec_rw] <= new_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++)
        free_list[i] <= (i < FREE_INIT) ? PW'(ARCH_REGS + i) : '0;
      head         <= '0;
      tail         <= PW'(FREE_INIT);
      free_count   <= INIT_CNT;
      overflow_err <= 1'b0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (push) begin
        free_list[tail] <= commit_free_phys;
        tail            <= tail + 1'b1;
      end
      case ({pop, push})
        2'b10:   free_count <= free_count - 1'b1;
        2'b01:   free_count <= free_count + 1'b1;
        default: free_count <= free_count;
      endcase
      if (commit_req && (free_count == FULL_CNT)) overflow_err <= 1'b1;
    end
  end

  // clear first so a coincident allocation of the same tag leaves it busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_valid && (wb_phys != '0)) busy[wb_phys] <= 1'b0;
      if (pop) busy[new_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_valid       <= 1'b0;
      ren_uses_rs     <= 1'b0;
      ren_uses_rt     <= 1'b0;
      ren_uses_rw     <= 1'b0;
      ren_rs_phys     <= '0;
      ren_rt_phys     <= '0;
      ren_rw_phys     <= '0;
      ren_old_rw_phys <= '0;
      ren_rs_busy     <= 1'b0;
      ren_rt_busy     <= 1'b0;
    end else begin
      ren_valid <= accept;
      if (accept) begin
        ren_uses_rs     <= dec_uses_rs;
        ren_uses_rt     <= dec_uses_rt;
        ren_uses_rw     <= alloc;
        ren_rs_phys     <= rs_tag;
        ren_rt_phys     <= rt_tag;
        ren_rw_phys     <= alloc ? new_tag : '0;
        ren_old_rw_phys <= alloc ? old_tag : '0;
        ren_rs_busy     <= rs_busy;
        ren_rt_busy     <= rt_busy;
      end
    end
  end

endmodule
